bicubic_win_fetch: RTL and testbench
====================================

// Module: bicubic_win_fetch
// PURPOSE
//  Fetches the 4x4 source-pixel neighbourhood needed by the bicubic interpolation core.
//  Sits between the image ROM and the interpolator. Accepts an integer source coordinate,
//  reads the clamped 4x4 window from the ROM and presents it as one 128-bit word.
//  A column cache cuts ROM traffic for raster-order requests.
// PARAMETERS
//  IMG_W   100  image width in pixels (ROM row pitch)
//  IMG_H   100  image height in pixels
//  AW      14   ROM address width
// PORTS
//  CLK        in   1    clock; all logic on rising edge
//  RST        in   1    synchronous reset, active-high
//  flush      in   1    invalidate window cache (new pattern/ROI)
//  req_valid  in   1    request valid
//  req_ready  out  1    block can accept request
//  req_x      in   7    integer source column x (0..IMG_W-1)
//  req_y      in   7    integer source row y (0..IMG_H-1)
//  rom_cen    out  1    ROM chip enable, active-low
//  rom_a      out  AW   ROM address = row*IMG_W + col
//  rom_q      in   8    ROM data, valid 1 cycle after rom_cen=0 with rom_a
//  win_valid  out  1    window valid
//  win_ready  in   1    consumer accepts window
//  win_data   out  128  p[r][c] at bits [(r*4+c)*8 +: 8], r,c in 0..3
// BEHAVIOUR
//  Reset values: req_ready=0, rom_cen=1, rom_a=0, win_valid=0, win_data=0, cache invalid.
//  Window: p[r][c] = IMG[clampY(y-1+r)][clampX(x-1+c)]; clamp to [0,IMG-1] on each axis.
//  Reuse rules, evaluated at accept (req_valid & req_ready):
//   - cache valid, same (x,y) as last window: N=0 reads.
//   - cache valid, same y, x == last_x+1: shift cols 1..3 to 0..2, fetch col 3 only, N=4.
//   - otherwise: N=16.
//  FSM: IDLE -> (accept, N>0) FETCH; IDLE -> (accept, N=0) OUT.
//   FETCH: one address per cycle, column-major, rows 0..3 within a column.
//   FETCH -> LAST after the Nth address. LAST captures the final rom_q, then goes to OUT.
//   OUT: win_valid=1 and win_data held stable until win_ready. OUT -> IDLE on win_ready.
//  req_ready=1 only in IDLE. rom_cen=0 only in cycles where an address is issued.
//  Capture rule: rom_q is captured the cycle after its address is issued.
//  Latency, accept edge to first win_valid cycle: N+2 cycles if N>0, 1 cycle if N=0.
//  After the window handshake, cache = {last_x, last_y, window}, marked valid.
//  Stored last_x/last_y are the unclamped request coordinates.
//  flush: sampled every cycle and clears cache-valid.
//   If flush coincides with accept, the request takes the full N=16 path.
//   A window in flight still completes.
//  Arithmetic: row*IMG_W computed as an unsigned AW-bit product. Max address 9999 fits 14 b.
//  RST mid-operation: abort fetch, drop window, return to IDLE, cache invalid, rom_cen=1.
//  req_x/req_y are ignored outside accept; request fields are registered at accept.
// TESTING
//  T1 req (10,20), cold cache -> 16 ROM reads, first rom_a=19*100+9=1909;
//     win_valid at accept+18; p[1][1]=IMG[20][10].
//  T2 after T1, req (11,20) -> 4 reads at col 13, rows 19..22 (1913,2013,2113,2213);
//     win_valid at accept+6; window matches a fresh fetch.
//  T3 req (0,0) -> clamped addresses; p[0][0]=p[0][1]=p[1][0]=p[1][1]=IMG[0][0].
//     req (99,99): p[3][3]=IMG[99][99].
//  T4 hold win_ready=0 for 5 cycles -> win_valid, win_data stable, req_ready=0, rom_cen=1.
//  T5 flush with a repeat of the last request -> 16 reads (no reuse).
//     Repeat without flush -> 0 reads, win_valid at accept+1.
//  T6 RST during FETCH (after 7 reads) -> next cycle IDLE, outputs at reset values.
//     Next req (11,20) takes the full 16-read path.

Source files
------------

// File: rtl/bicubic_win_fetch_if.sv
// Request, ROM and window buses of the bicubic 4x4 window fetcher.
// master = fetcher side, slave = environment side.
interface bicubic_win_fetch_if #(
   parameter int AW = 14
);
   logic          req_valid;
   logic          req_ready;
   logic [6:0]    req_x;
   logic [6:0]    req_y;
   logic          rom_cen;
   logic [AW-1:0] rom_a;
   logic [7:0]    rom_q;
   logic          win_valid;
   logic          win_ready;
   logic [127:0]  win_data;

   modport master (
      input  req_valid, req_x, req_y, rom_q, win_ready,
      output req_ready, rom_cen, rom_a, win_valid, win_data
   );

   modport slave (
      output req_valid, req_x, req_y, rom_q, win_ready,
      input  req_ready, rom_cen, rom_a, win_valid, win_data
   );
endinterface

// File: rtl/bicubic_win_fetch.sv
// Fetches a clamped 4x4 pixel window from the image ROM for the bicubic core,
// reusing the previous window when the request repeats or steps one column right.
module bicubic_win_fetch #(
   parameter int IMG_W = 100,
   parameter int IMG_H = 100,
   parameter int AW    = 14
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                flush,
   bicubic_win_fetch_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_OUT} state_t;

   state_t        r_state, w_nstate;
   logic [6:0]    r_x, r_y, r_lx, r_ly;
   logic          r_cv, r_shift;
   logic [3:0]    r_cnt;
   logic          r_cap_en;
   logic [3:0]    r_cap_sl;
   logic [127:0]  r_win;

   logic          w_acc, w_hit, w_shift;
   logic [3:0]    w_last;
   logic [1:0]    w_row, w_col;
   logic [8:0]    w_yy, w_xx;
   logic [6:0]    w_cy, w_cx;
   logic [AW-1:0] w_addr;

   assign w_acc   = bus.req_valid & bus.req_ready;
   assign w_hit   = r_cv & ~flush & (bus.req_x == r_lx) & (bus.req_y == r_ly);
   assign w_shift = r_cv & ~flush & (bus.req_y == r_ly)
                  & ({1'b0, bus.req_x} == ({1'b0, r_lx} + 8'd1));
   assign w_last  = r_shift ? 4'd3 : 4'd15;
   assign w_row   = r_cnt[1:0];
   assign w_col   = r_shift ? 2'd3 : r_cnt[3:2];

   // 9-bit wrap makes coordinate -1 appear as a set MSB
   always_comb begin
      w_yy = {2'b00, r_y} + {7'd0, w_row} - 9'd1;
      w_xx = {2'b00, r_x} + {7'd0, w_col} - 9'd1;
      w_cy = w_yy[8] ? 7'd0 :
             (w_yy > 9'(IMG_H - 1)) ? 7'(IMG_H - 1) : w_yy[6:0];
      w_cx = w_xx[8] ? 7'd0 :
             (w_xx > 9'(IMG_W - 1)) ? 7'(IMG_W - 1) : w_xx[6:0];
      w_addr = AW'(w_cy) * AW'(IMG_W) + AW'(w_cx);
   end

   assign bus.req_ready = (r_state == S_IDLE) & ~RST;
   assign bus.rom_cen   = (r_state != S_FETCH);
   assign bus.rom_a     = (r_state == S_FETCH) ? w_addr : '0;
   assign bus.win_valid = (r_state == S_OUT);
   assign bus.win_data  = r_win;

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         S_IDLE:  if (w_acc) w_nstate = w_hit ? S_OUT : S_FETCH;
         S_FETCH: if (r_cnt == w_last) w_nstate = S_LAST;
         S_LAST:  w_nstate = S_OUT;
         S_OUT:   if (bus.win_ready) w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_x      <= '0;
         r_y      <= '0;
         r_lx     <= '0;
         r_ly     <= '0;
         r_cv     <= 1'b0;
         r_shift  <= 1'b0;
         r_cnt    <= '0;
         r_cap_en <= 1'b0;
         r_cap_sl <= '0;
         r_win    <= '0;
      end else begin
         // ROM data lands one cycle after its address; remember where it goes
         r_cap_en <= (r_state == S_FETCH);
         r_cap_sl <= {w_row, w_col};
         if (r_cap_en) r_win[{r_cap_sl, 3'b000} +: 8] <= bus.rom_q;
         if (w_acc) begin
            r_x     <= bus.req_x;
            r_y     <= bus.req_y;
            r_shift <= w_shift;
            r_cnt   <= '0;
            if (w_shift) begin
               for (int r = 0; r < 4; r++)
                  for (int c = 0; c < 3; c++)
                     r_win[(r*4+c)*8 +: 8] <= r_win[(r*4+c+1)*8 +: 8];
            end
         end else if (r_state == S_FETCH && r_cnt != w_last) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (bus.win_valid & bus.win_ready) begin
            r_cv <= 1'b1;
            r_lx <= r_x;
            r_ly <= r_y;
         end
         if (flush) r_cv <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bicubic_win_fetch.sv
// Directed bench for bicubic_win_fetch: cold fetch, column reuse, clamping,
// back-pressure, flush and mid-fetch reset against a synthetic 100x100 ROM.
module tb_bicubic_win_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   bicubic_win_fetch_if #(.AW(14)) bus ();

   bicubic_win_fetch #(.IMG_W(100), .IMG_H(100), .AW(14)) dut (
      .CLK(clk), .RST(rst), .flush(flush), .bus(bus)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int rq[$];

   function automatic logic [7:0] img(int r, int c);
      return 8'((r * 37 + c * 11 + 3) & 255);
   endfunction

   function automatic int clampi(int v, int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [127:0] exp_win(int x, int y);
      logic [127:0] w;
      w = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            w[(r*4+c)*8 +: 8] = img(clampi(y - 1 + r, 99), clampi(x - 1 + c, 99));
      return w;
   endfunction

   // synchronous ROM model
   always @(posedge clk)
      if (bus.rom_cen === 1'b0)
         bus.rom_q <= img(int'(bus.rom_a) / 100, int'(bus.rom_a) % 100);

   always @(negedge clk)
      if (bus.rom_cen === 1'b0) rq.push_back(int'(bus.rom_a));

   task automatic do_req(input int x, input int y, input logic fl,
                         output int lat, output logic to);
      int k;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_x = 7'(x);
      bus.req_y = 7'(y);
      flush = fl;
      to = 1'b1;
      lat = 0;
      k = 0;
      while (!bus.req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (bus.req_ready) begin
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
         bus.req_x = 7'h55;
         bus.req_y = 7'h2a;
         flush = 1'b0;
         rq.delete();
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.win_valid) begin
               to = 1'b0;
               break;
            end
         end
      end else begin
         bus.req_valid = 1'b0;
         flush = 1'b0;
      end
   endtask

   task automatic take(output logic [127:0] d);
      d = bus.win_data;
      bus.win_ready = 1'b1;
      @(posedge clk);
      #1 bus.win_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b0 || bus.rom_cen !== 1'b1 || bus.rom_a !== 14'd0
          || bus.win_valid !== 1'b0 || bus.win_data !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b cen=%b a=%0d wv=%b wd=%h",
                  bus.req_ready, bus.rom_cen, bus.rom_a, bus.win_valid, bus.win_data);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_cold();
      int lat;
      logic to;
      logic [127:0] d;
      bit bad;
      do_req(10, 20, 1'b0, lat, to);
      n_cmp++;
      if (to !== 1'b0 || lat !== 18) begin
         n_fail++;
         $display("FAIL cold_latency: got %0d (timeout %b) want 18", lat, to);
      end
      n_cmp++;
      if (rq.size() !== 16 || rq[0] !== 1909) begin
         n_fail++;
         $display("FAIL cold_reads: got %0d reads first %0d want 16 first 1909",
                  rq.size(), rq.size() > 0 ? rq[0] : -1);
      end
      bad = 0;
      for (int k = 0; k < 16 && k < rq.size(); k++)
         if (rq[k] !== clampi(19 + k % 4, 99) * 100 + clampi(9 + k / 4, 99)) bad = 1;
      n_cmp++;
      if (bad) begin
         n_fail++;
         $display("FAIL cold_addr_order: column-major address sequence wrong");
      end
      take(d);
      n_cmp++;
      if (d[5*8 +: 8] !== img(20, 10)) begin
         n_fail++;
         $display("FAIL cold_p11: got %h want %h", d[5*8 +: 8], img(20, 10));
      end
      n_cmp++;
      if (d !== exp_win(10, 20)) begin
         n_fail++;
         $display("FAIL cold_window: got %h want %h", d, exp_win(10, 20));
      end
   endtask

   task automatic test_shift();
      int lat;
      logic to;
      logic [127:0] d;
      int ea[4] = '{1913, 2013, 2113, 2213};
      bit bad;
      do_req(11, 20, 1'b0, lat, to);
      n_cmp++;
      if (to !== 1'b0 || lat !== 6) begin
         n_fail++;
         $display("FAIL shift_latency: got %0d (timeout %b) want 6", lat, to);
      end
      bad = (rq.size() != 4);
      for (int k = 0; k < 4 && k < rq.size(); k++)
         if (rq[k] !== ea[k]) bad = 1;
      n_cmp++;
      if (bad) begin
         n_fail++;
         $display("FAIL shift_reads: got %0d reads first %0d want 4 reads 1913..2213",
                  rq.size(), rq.size() > 0 ? rq[0] : -1);
      end
      take(d);
      n_cmp++;
      if (d !== exp_win(11, 20)) begin
         n_fail++;
         $display("FAIL shift_window: got %h want %h", d, exp_win(11, 20));
      end
   endtask

   task automatic test_clamp();
      int lat;
      logic to;
      logic [127:0] d;
      do_req(0, 0, 1'b0, lat, to);
      n_cmp++;
      if (to !== 1'b0 || rq.size() !== 16 || rq[0] !== 0) begin
         n_fail++;
         $display("FAIL clamp_lo_reads: got %0d reads timeout %b want 16 from addr 0",
                  rq.size(), to);
      end
      take(d);
      n_cmp++;
      if (d[0 +: 8] !== img(0, 0) || d[8 +: 8] !== img(0, 0)
          || d[32 +: 8] !== img(0, 0) || d[40 +: 8] !== img(0, 0)) begin
         n_fail++;
         $display("FAIL clamp_lo_corner: got %h %h %h %h want %h",
                  d[0 +: 8], d[8 +: 8], d[32 +: 8], d[40 +: 8], img(0, 0));
      end
      n_cmp++;
      if (d !== exp_win(0, 0)) begin
         n_fail++;
         $display("FAIL clamp_lo_window: got %h want %h", d, exp_win(0, 0));
      end
      do_req(99, 99, 1'b0, lat, to);
      take(d);
      n_cmp++;
      if (to !== 1'b0 || d[15*8 +: 8] !== img(99, 99)) begin
         n_fail++;
         $display("FAIL clamp_hi_p33: got %h want %h", d[15*8 +: 8], img(99, 99));
      end
      n_cmp++;
      if (d !== exp_win(99, 99)) begin
         n_fail++;
         $display("FAIL clamp_hi_window: got %h want %h", d, exp_win(99, 99));
      end
   endtask

   task automatic test_hold();
      int lat;
      logic to;
      logic [127:0] d0, d;
      do_req(5, 50, 1'b0, lat, to);
      d0 = bus.win_data;
      n_cmp++;
      if (to !== 1'b0 || d0 !== exp_win(5, 50)) begin
         n_fail++;
         $display("FAIL hold_window: got %h want %h", d0, exp_win(5, 50));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.win_valid !== 1'b1 || bus.win_data !== d0
             || bus.req_ready !== 1'b0 || bus.rom_cen !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: wv=%b ready=%b cen=%b data_changed=%b want 1/0/1/0",
                     i, bus.win_valid, bus.req_ready, bus.rom_cen, bus.win_data !== d0);
         end
      end
      take(d);
      @(negedge clk);
      n_cmp++;
      if (bus.win_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_release: wv=%b ready=%b want 0/1", bus.win_valid, bus.req_ready);
      end
   endtask

   task automatic test_flush();
      int lat;
      logic to;
      logic [127:0] d;
      do_req(5, 50, 1'b1, lat, to);
      n_cmp++;
      if (to !== 1'b0 || lat !== 18 || rq.size() !== 16) begin
         n_fail++;
         $display("FAIL flush_full: got lat %0d reads %0d want lat 18 reads 16",
                  lat, rq.size());
      end
      take(d);
      n_cmp++;
      if (d !== exp_win(5, 50)) begin
         n_fail++;
         $display("FAIL flush_window: got %h want %h", d, exp_win(5, 50));
      end
      do_req(5, 50, 1'b0, lat, to);
      n_cmp++;
      if (to !== 1'b0 || lat !== 1 || rq.size() !== 0) begin
         n_fail++;
         $display("FAIL repeat_hit: got lat %0d reads %0d want lat 1 reads 0",
                  lat, rq.size());
      end
      take(d);
      n_cmp++;
      if (d !== exp_win(5, 50)) begin
         n_fail++;
         $display("FAIL repeat_window: got %h want %h", d, exp_win(5, 50));
      end
   endtask

   task automatic test_rst_mid();
      int lat;
      int k;
      logic to;
      logic [127:0] d;
      do_req(10, 20, 1'b0, lat, to);
      take(d);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_x = 7'd30;
      bus.req_y = 7'd40;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      rq.delete();
      k = 0;
      while (rq.size() < 7 && k < 40) begin
         @(posedge clk);
         k++;
      end
      n_cmp++;
      if (rq.size() !== 7) begin
         n_fail++;
         $display("FAIL rst_pre_reads: got %0d want 7", rq.size());
      end
      #1 rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.rom_cen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_fetch: cen=%b want 0 before reset edge", bus.rom_cen);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b0 || bus.rom_cen !== 1'b1 || bus.rom_a !== 14'd0
          || bus.win_valid !== 1'b0 || bus.win_data !== 128'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: ready=%b cen=%b a=%0d wv=%b wd=%h",
                  bus.req_ready, bus.rom_cen, bus.rom_a, bus.win_valid, bus.win_data);
      end
      rst = 1'b0;
      do_req(11, 20, 1'b0, lat, to);
      n_cmp++;
      if (to !== 1'b0 || lat !== 18 || rq.size() !== 16) begin
         n_fail++;
         $display("FAIL rst_cache_cold: got lat %0d reads %0d want lat 18 reads 16",
                  lat, rq.size());
      end
      take(d);
      n_cmp++;
      if (d !== exp_win(11, 20)) begin
         n_fail++;
         $display("FAIL rst_window: got %h want %h", d, exp_win(11, 20));
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_x = '0;
      bus.req_y = '0;
      bus.win_ready = 1'b0;
      bus.rom_q = '0;
      test_reset();
      test_cold();
      test_shift();
      test_clamp();
      test_hold();
      test_flush();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
